// File: rtl/irq_status8.sv
// Sticky event-status stage: latches OR-reduced events into pending/overflow flags,
// gates them with an enable mask and offers one pending index at a time.
module irq_status8 #(
    parameter int WIDTH = 8,
    parameter int ID_W  = 3
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] EV,
    input  logic             MASK_WE,
    input  logic [WIDTH-1:0] MASK_D,
    input  logic [WIDTH-1:0] OVF_CLR,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic [ID_W-1:0]  O_ID,
    output logic             IRQ,
    output logic [WIDTH-1:0] PEND,
    output logic [WIDTH-1:0] OVF,
    output logic [WIDTH-1:0] MASK
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;

    logic [0:0]       state;
    logic             acc;
    logic [WIDTH-1:0] clr_vec;
    logic [WIDTH-1:0] pend_nxt;
    logic [WIDTH-1:0] ovf_nxt;
    logic [WIDTH-1:0] req;
    logic [ID_W-1:0]  sel;
    logic             any;

    assign acc = O_VALID & O_READY;
    assign req = PEND & MASK;
    assign any = |req;

    always_comb begin
        clr_vec = '0;
        if (acc) clr_vec[O_ID] = 1'b1;
    end

    // A fresh event always wins over the clear from an accept or OVF_CLR.
    assign pend_nxt = EV | (PEND & ~clr_vec);
    assign ovf_nxt  = (OVF & ~OVF_CLR) | (EV & PEND & ~clr_vec);

    // Descending scan so the lowest enabled pending index is the one that sticks.
    always_comb begin
        sel = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) sel = ID_W'(i);
        end
    end

    // Stage p0: flag capture, mask and interrupt summary
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            PEND <= '0;
            OVF  <= '0;
            MASK <= '1;
            IRQ  <= 1'b0;
        end else begin
            PEND <= pend_nxt;
            OVF  <= ovf_nxt;
            if (MASK_WE) MASK <= MASK_D;
            IRQ  <= |(PEND & MASK);
        end
    end

    // Stage p1: offer FSM; O_ID stays frozen for the whole OFFER state
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state   <= IDLE;
            O_VALID <= 1'b0;
            O_ID    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        O_ID    <= sel;
                        O_VALID <= 1'b1;
                        state   <= OFFER;
                    end
                end
                OFFER: begin
                    if (acc) begin
                        O_VALID <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    O_VALID <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_status8.sv
// Directed bench for irq_status8: reset, single event, stall, overflow, masking,
// same-cycle re-fire and full in-order drain.
module tb_irq_status8;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic [7:0] EV, MASK_D, OVF_CLR, PEND, OVF, MASK;
    logic       MASK_WE, O_VALID, O_READY, IRQ;
    logic [2:0] O_ID;

    int pass_cnt = 0;
    int total_cnt = 0;

    irq_status8 #(.WIDTH(8), .ID_W(3)) dut (
        .CLK(CLK), .RESETN(RESETN), .EV(EV), .MASK_WE(MASK_WE), .MASK_D(MASK_D),
        .OVF_CLR(OVF_CLR), .O_VALID(O_VALID), .O_READY(O_READY), .O_ID(O_ID),
        .IRQ(IRQ), .PEND(PEND), .OVF(OVF), .MASK(MASK)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESETN = 1'b0; EV = '0; MASK_WE = 1'b0; MASK_D = '0; OVF_CLR = '0; O_READY = 1'b0;
        tick(); tick();
        RESETN = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if ({PEND, OVF, O_VALID, IRQ} !== 18'h0) $display("FAIL rst_init flags=%h req=0", {PEND, OVF, O_VALID, IRQ}); else pass_cnt++;
        total_cnt++; if (MASK !== 8'hFF) $display("FAIL rst_mask got=%h req=ff", MASK); else pass_cnt++;
        EV = 8'hFF; tick();
        EV = 8'h00; tick();
        total_cnt++; if (O_VALID !== 1'b1 || O_ID !== 3'd0) $display("FAIL rst_preoffer v=%b id=%0d req v=1 id=0", O_VALID, O_ID); else pass_cnt++;
        // Reset mid-offer with events still firing; must act without a clock edge.
        EV = 8'hFF; RESETN = 1'b0; #1;
        total_cnt++; if ({PEND, OVF, O_VALID, IRQ, O_ID} !== 21'h0) $display("FAIL rst_async state=%h req=0", {PEND, OVF, O_VALID, IRQ, O_ID}); else pass_cnt++;
        total_cnt++; if (MASK !== 8'hFF) $display("FAIL rst_async_mask got=%h req=ff", MASK); else pass_cnt++;
        tick();
        RESETN = 1'b1;
        tick();
        total_cnt++; if (PEND !== 8'hFF || OVF !== 8'h00) $display("FAIL rst_first_edge pend=%h ovf=%h req ff/00", PEND, OVF); else pass_cnt++;
        do_reset();
    endtask

    task automatic test_single();
        EV = 8'h10; tick();
        total_cnt++; if (PEND !== 8'h10 || O_VALID !== 1'b0) $display("FAIL single_latch pend=%h v=%b req 10/0", PEND, O_VALID); else pass_cnt++;
        EV = 8'h00; O_READY = 1'b1; tick();
        total_cnt++; if (O_VALID !== 1'b1 || O_ID !== 3'd4 || IRQ !== 1'b1) $display("FAIL single_offer v=%b id=%0d irq=%b req 1/4/1", O_VALID, O_ID, IRQ); else pass_cnt++;
        tick();
        total_cnt++; if (PEND !== 8'h00 || O_VALID !== 1'b0) $display("FAIL single_acc pend=%h v=%b req 00/0", PEND, O_VALID); else pass_cnt++;
        tick();
        total_cnt++; if (IRQ !== 1'b0 || O_VALID !== 1'b0) $display("FAIL single_irq_fall irq=%b v=%b req 0/0", IRQ, O_VALID); else pass_cnt++;
        O_READY = 1'b0;
    endtask

    task automatic test_stall();
        EV = 8'h81; tick();
        total_cnt++; if (PEND !== 8'h81) $display("FAIL stall_latch pend=%h req=81", PEND); else pass_cnt++;
        EV = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++; if (O_VALID !== 1'b1 || O_ID !== 3'd0) $display("FAIL stall_hold%0d v=%b id=%0d req 1/0", i, O_VALID, O_ID); else pass_cnt++;
        end
        O_READY = 1'b1; tick();
        total_cnt++; if (O_VALID !== 1'b0 || PEND !== 8'h80) $display("FAIL stall_bubble v=%b pend=%h req 0/80", O_VALID, PEND); else pass_cnt++;
        tick();
        total_cnt++; if (O_VALID !== 1'b1 || O_ID !== 3'd7) $display("FAIL stall_second v=%b id=%0d req 1/7", O_VALID, O_ID); else pass_cnt++;
        tick();
        total_cnt++; if (O_VALID !== 1'b0 || PEND !== 8'h00) $display("FAIL stall_done v=%b pend=%h req 0/00", O_VALID, PEND); else pass_cnt++;
        O_READY = 1'b0; tick();
    endtask

    task automatic test_overflow();
        EV = 8'h04; tick();
        total_cnt++; if (PEND !== 8'h04 || OVF !== 8'h00) $display("FAIL ovf_first pend=%h ovf=%h req 04/00", PEND, OVF); else pass_cnt++;
        tick();
        total_cnt++; if (OVF !== 8'h04) $display("FAIL ovf_set got=%h req=04", OVF); else pass_cnt++;
        OVF_CLR = 8'h04; tick();
        total_cnt++; if (OVF !== 8'h04) $display("FAIL ovf_set_wins got=%h req=04", OVF); else pass_cnt++;
        EV = 8'h00; tick();
        total_cnt++; if (OVF !== 8'h00 || PEND !== 8'h04) $display("FAIL ovf_clear ovf=%h pend=%h req 00/04", OVF, PEND); else pass_cnt++;
        OVF_CLR = 8'h00;
        total_cnt++; if (O_VALID !== 1'b1 || O_ID !== 3'd2) $display("FAIL ovf_offer v=%b id=%0d req 1/2", O_VALID, O_ID); else pass_cnt++;
        O_READY = 1'b1; tick();
        total_cnt++; if (PEND !== 8'h00 || OVF !== 8'h00) $display("FAIL ovf_acc pend=%h ovf=%h req 00/00", PEND, OVF); else pass_cnt++;
        O_READY = 1'b0; tick();
    endtask

    task automatic test_mask();
        MASK_WE = 1'b1; MASK_D = 8'hFE; tick();
        total_cnt++; if (MASK !== 8'hFE) $display("FAIL mask_write got=%h req=fe", MASK); else pass_cnt++;
        MASK_WE = 1'b0; EV = 8'h01; tick();
        total_cnt++; if (PEND !== 8'h01) $display("FAIL mask_latch pend=%h req=01", PEND); else pass_cnt++;
        EV = 8'h00; tick(); tick();
        total_cnt++; if (IRQ !== 1'b0 || O_VALID !== 1'b0) $display("FAIL mask_quiet irq=%b v=%b req 0/0", IRQ, O_VALID); else pass_cnt++;
        MASK_WE = 1'b1; MASK_D = 8'hFF; tick();
        MASK_WE = 1'b0;
        total_cnt++; if (MASK !== 8'hFF || O_VALID !== 1'b0) $display("FAIL mask_reopen mask=%h v=%b req ff/0", MASK, O_VALID); else pass_cnt++;
        tick();
        total_cnt++; if (IRQ !== 1'b1 || O_VALID !== 1'b1 || O_ID !== 3'd0) $display("FAIL mask_offer irq=%b v=%b id=%0d req 1/1/0", IRQ, O_VALID, O_ID); else pass_cnt++;
        O_READY = 1'b1; tick();
        total_cnt++; if (PEND !== 8'h00) $display("FAIL mask_acc pend=%h req=00", PEND); else pass_cnt++;
        O_READY = 1'b0; tick();
    endtask

    task automatic test_back_to_back();
        EV = 8'h08; tick();
        EV = 8'h00; tick();
        total_cnt++; if (O_VALID !== 1'b1 || O_ID !== 3'd3) $display("FAIL b2b_offer v=%b id=%0d req 1/3", O_VALID, O_ID); else pass_cnt++;
        EV = 8'h08; O_READY = 1'b1; tick();
        total_cnt++; if (PEND !== 8'h08 || OVF !== 8'h00 || O_VALID !== 1'b0) $display("FAIL b2b_refire pend=%h ovf=%h v=%b req 08/00/0", PEND, OVF, O_VALID); else pass_cnt++;
        EV = 8'h00; tick();
        total_cnt++; if (O_VALID !== 1'b1 || O_ID !== 3'd3) $display("FAIL b2b_reoffer v=%b id=%0d req 1/3", O_VALID, O_ID); else pass_cnt++;
        tick();
        total_cnt++; if (PEND !== 8'h00 || O_VALID !== 1'b0) $display("FAIL b2b_done pend=%h v=%b req 00/0", PEND, O_VALID); else pass_cnt++;
        O_READY = 1'b0; tick();
    endtask

    task automatic test_drain_all();
        EV = 8'hFF; tick();
        EV = 8'h00; O_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total_cnt++; if (O_VALID !== 1'b1 || O_ID !== 3'(i)) $display("FAIL drain_offer%0d v=%b id=%0d req 1/%0d", i, O_VALID, O_ID, i); else pass_cnt++;
            tick();
            total_cnt++; if (O_VALID !== 1'b0) $display("FAIL drain_bubble%0d v=%b req 0", i, O_VALID); else pass_cnt++;
        end
        total_cnt++; if (PEND !== 8'h00) $display("FAIL drain_empty pend=%h req=00", PEND); else pass_cnt++;
        O_READY = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        test_mask();
        test_back_to_back();
        test_drain_all();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
